dec_burst: RTL and testbench

DEC_BURST -- requirements
Module: dec_burst

---
 rtl/dec_burst.sv | 58 +++++
 tb/tb_dec_burst.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dec_burst.sv
// rtl/dec_burst.sv - decrementing burst generator: each accepted word yields COUNT successively decremented words
module dec_burst #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int COUNT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_borrow
);

  localparam int RW = (COUNT < 2) ? 1 : $clog2(COUNT + 1);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [RW-1:0]    REM_TOP = RW'(COUNT - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]    state;
  logic [RW-1:0] rem;
  logic          in_xfer;
  logic          out_xfer;

  // A new word may enter only when the last word of the current burst leaves
  assign in_ready  = !rst && ((state == IDLE) || (out_ready && (rem == '0)));
  assign out_valid = (state == BURST);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      out_data   <= '0;
      out_borrow <= 1'b0;
    end else if (in_xfer) begin
      state      <= BURST;
      rem        <= REM_TOP;
      out_data   <= in_data - STEP_W;
      out_borrow <= (in_data < STEP_W);
    end else if (out_xfer) begin
      if (rem != '0) begin
        rem        <= rem - 1'b1;
        out_data   <= out_data - STEP_W;
        out_borrow <= (out_data < STEP_W);
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_dec_burst.sv
// tb/tb_dec_burst.sv - self-checking bench for dec_burst
module tb_dec_burst;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Four single-word instances with different steps share one input stream
  logic       rst_t, t_in_valid, t_out_ready;
  logic [7:0] t_in_data;
  logic       t_in_ready [4];
  logic       t_out_valid[4];
  logic [7:0] t_out_data [4];
  logic       t_out_borrow[4];

  dec_burst #(.WIDTH(8), .STEP(0), .COUNT(1)) u_s0 (
    .clk(clk), .rst(rst_t), .in_valid(t_in_valid), .in_ready(t_in_ready[0]), .in_data(t_in_data),
    .out_valid(t_out_valid[0]), .out_ready(t_out_ready), .out_data(t_out_data[0]), .out_borrow(t_out_borrow[0]));
  dec_burst #(.WIDTH(8), .STEP(1), .COUNT(1)) u_s1 (
    .clk(clk), .rst(rst_t), .in_valid(t_in_valid), .in_ready(t_in_ready[1]), .in_data(t_in_data),
    .out_valid(t_out_valid[1]), .out_ready(t_out_ready), .out_data(t_out_data[1]), .out_borrow(t_out_borrow[1]));
  dec_burst #(.WIDTH(8), .STEP(3), .COUNT(1)) u_s3 (
    .clk(clk), .rst(rst_t), .in_valid(t_in_valid), .in_ready(t_in_ready[2]), .in_data(t_in_data),
    .out_valid(t_out_valid[2]), .out_ready(t_out_ready), .out_data(t_out_data[2]), .out_borrow(t_out_borrow[2]));
  dec_burst #(.WIDTH(8), .STEP(7), .COUNT(1)) u_s7 (
    .clk(clk), .rst(rst_t), .in_valid(t_in_valid), .in_ready(t_in_ready[3]), .in_data(t_in_data),
    .out_valid(t_out_valid[3]), .out_ready(t_out_ready), .out_data(t_out_data[3]), .out_borrow(t_out_borrow[3]));

  localparam int STEP_B  = 2;
  localparam int COUNT_B = 3;

  logic       rst_b, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_borrow;
  logic [7:0] b_in_data, b_out_data;

  dec_burst #(.WIDTH(8), .STEP(STEP_B), .COUNT(COUNT_B)) u_b (
    .clk(clk), .rst(rst_b), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_borrow(b_out_borrow));

  typedef struct {
    logic [7:0] din;
    logic [7:0] e1; logic b1;
    logic [7:0] e3; logic b3;
    logic [7:0] e7; logic b7;
  } vec_t;
  vec_t tab[9];

  // Reference for the burst instance: the words still owed downstream, oldest first
  typedef struct { logic [7:0] d; logic b; } word_t;
  word_t q[$];

  logic [7:0] smp_data;
  logic       smp_ready;

  task automatic push_burst(input logic [7:0] x);
    int v;
    for (int k = 0; k < COUNT_B; k++) begin
      word_t w;
      v   = int'(x) - STEP_B * k;
      w.b = ((v % 256 + 256) % 256) < STEP_B;
      w.d = 8'((v - STEP_B) % 256 + 256);
      q.push_back(w);
    end
  endtask

  task automatic cycle_b(input logic iv, input logic [7:0] d, input logic ordy);
    logic exp_ready, acc_in, acc_out;
    b_in_valid = iv; b_in_data = d; b_out_ready = ordy;
    @(negedge clk);
    exp_ready = (q.size() == 0) || (q.size() == 1 && ordy);
    chk("b_out_valid", 32'(b_out_valid), 32'(q.size() != 0));
    chk("b_in_ready", 32'(b_in_ready), 32'(exp_ready));
    if (q.size() != 0) begin
      chk("b_out_data", 32'(b_out_data), 32'(q[0].d));
      chk("b_out_borrow", 32'(b_out_borrow), 32'(q[0].b));
    end
    smp_data = b_out_data; smp_ready = b_in_ready;
    acc_in  = iv && exp_ready;
    acc_out = ordy && (q.size() != 0);
    @(posedge clk);
    if (acc_out) void'(q.pop_front());
    if (acc_in) push_burst(d);
    #1;
  endtask

  task automatic reset_b();
    rst_b = 1'b1; b_in_valid = 1'b1; b_in_data = 8'($urandom); b_out_ready = 1'b1;
    @(negedge clk);
    chk("b_in_ready_in_rst", 32'(b_in_ready), 32'd0);
    @(posedge clk);
    q.delete();
    #1;
    rst_b = 1'b0; b_in_valid = 1'b0;
    @(negedge clk);
    chk("b_rst_valid", 32'(b_out_valid), 32'd0);
    chk("b_rst_data", 32'(b_out_data), 32'd0);
    chk("b_rst_borrow", 32'(b_out_borrow), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tab[0] = '{8'h10, 8'h0F, 1'b0, 8'h0D, 1'b0, 8'h09, 1'b0};
    tab[1] = '{8'h03, 8'h02, 1'b0, 8'h00, 1'b0, 8'hFC, 1'b1};
    tab[2] = '{8'h07, 8'h06, 1'b0, 8'h04, 1'b0, 8'h00, 1'b0};
    tab[3] = '{8'h01, 8'h00, 1'b0, 8'hFE, 1'b1, 8'hFA, 1'b1};
    tab[4] = '{8'h02, 8'h01, 1'b0, 8'hFF, 1'b1, 8'hFB, 1'b1};
    tab[5] = '{8'h03, 8'h02, 1'b0, 8'h00, 1'b0, 8'hFC, 1'b1};
    tab[6] = '{8'h04, 8'h03, 1'b0, 8'h01, 1'b0, 8'hFD, 1'b1};
    tab[7] = '{8'h00, 8'hFF, 1'b1, 8'hFD, 1'b1, 8'hF9, 1'b1};
    tab[8] = '{8'hFF, 8'hFE, 1'b0, 8'hFC, 1'b0, 8'hF8, 1'b0};

    rst_t = 1'b1; t_in_valid = 1'b1; t_in_data = 8'h55; t_out_ready = 1'b1;
    rst_b = 1'b1; b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("t_rst_valid", 32'(t_out_valid[k]), 32'd0);
      chk("t_rst_data", 32'(t_out_data[k]), 32'd0);
      chk("t_rst_borrow", 32'(t_out_borrow[k]), 32'd0);
      chk("t_rst_ready", 32'(t_in_ready[k]), 32'd0);
    end
    @(posedge clk); #1;
    rst_t = 1'b0; rst_b = 1'b0; t_in_valid = 1'b0;

    // Streamed table: a word every cycle, each result due the following cycle
    for (int i = 0; i <= 9; i++) begin
      logic [7:0] ed[4];
      logic       eb[4];
      t_in_valid = (i < 9);
      t_in_data  = (i < 9) ? tab[i].din : 8'hAA;
      @(negedge clk);
      for (int k = 0; k < 4; k++) chk("t_in_ready", 32'(t_in_ready[k]), 32'd1);
      if (i == 0) begin
        for (int k = 0; k < 4; k++) chk("t_idle_valid", 32'(t_out_valid[k]), 32'd0);
      end else begin
        ed[0] = tab[i-1].din; eb[0] = 1'b0;
        ed[1] = tab[i-1].e1;  eb[1] = tab[i-1].b1;
        ed[2] = tab[i-1].e3;  eb[2] = tab[i-1].b3;
        ed[3] = tab[i-1].e7;  eb[3] = tab[i-1].b7;
        for (int k = 0; k < 4; k++) begin
          chk("t_valid", 32'(t_out_valid[k]), 32'd1);
          chk("t_data", 32'(t_out_data[k]), 32'(ed[k]));
          chk("t_borrow", 32'(t_out_borrow[k]), 32'(eb[k]));
        end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk("t_drain_valid", 32'(t_out_valid[k]), 32'd0);
    @(posedge clk); #1;

    // Burst of three with a back-to-back second input
    cycle_b(1'b1, 8'h0A, 1'b1);
    chk("r29_ready_idle", 32'(smp_ready), 32'd1);
    cycle_b(1'b1, 8'h77, 1'b1);
    chk("r29_d0", 32'(smp_data), 32'h08);
    chk("r29_r0", 32'(smp_ready), 32'd0);
    cycle_b(1'b0, 8'h00, 1'b1);
    chk("r29_d1", 32'(smp_data), 32'h06);
    chk("r29_r1", 32'(smp_ready), 32'd0);
    cycle_b(1'b1, 8'h20, 1'b1);
    chk("r29_d2", 32'(smp_data), 32'h04);
    chk("r29_r2", 32'(smp_ready), 32'd1);
    cycle_b(1'b0, 8'h00, 1'b1);
    chk("r29_nobubble", 32'(smp_data), 32'h1E);
    cycle_b(1'b0, 8'h00, 1'b1);
    cycle_b(1'b0, 8'h00, 1'b1);

    // Stall mid-burst while an input is being offered
    cycle_b(1'b1, 8'h50, 1'b1);
    cycle_b(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle_b(1'b1, 8'h99, 1'b0);
      chk("r30_hold", 32'(smp_data), 32'h4C);
      chk("r30_ready", 32'(smp_ready), 32'd0);
    end
    cycle_b(1'b0, 8'h00, 1'b1);
    chk("r30_resume", 32'(smp_data), 32'h4C);
    cycle_b(1'b0, 8'h00, 1'b1);
    chk("r30_last", 32'(smp_data), 32'h4A);

    // Reset after the second output of a burst, then a full wrapping burst
    cycle_b(1'b1, 8'h30, 1'b1);
    cycle_b(1'b0, 8'h00, 1'b1);
    cycle_b(1'b0, 8'h00, 1'b1);
    reset_b();
    cycle_b(1'b1, 8'h05, 1'b1);
    cycle_b(1'b0, 8'h00, 1'b1);
    chk("r32_w0", 32'(smp_data), 32'h03);
    cycle_b(1'b0, 8'h00, 1'b1);
    chk("r32_w1", 32'(smp_data), 32'h01);
    cycle_b(1'b0, 8'h00, 1'b1);
    chk("r32_w2", 32'(smp_data), 32'hFF);
    cycle_b(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0) reset_b();
      else cycle_b(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
